// File: rtl/soc_system_gpio_pio.sv
// Parametrised Avalon-MM GPIO slave: direction, set/clear output writes,
// synchronised inputs with edge capture and a maskable interrupt.

module soc_system_gpio_pio_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    input  logic clr,
    output logic sync,
    output logic cap
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   edge_det;

    assign sync = chain[SYNC_STAGES-1];

    always_comb begin
        edge_det = 1'b0;
        case (EDGE_TYPE)
            0:       edge_det = sync & ~prev;
            1:       edge_det = ~sync & prev;
            default: edge_det = sync ^ prev;
        endcase
    end

    // A detected edge overrides a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
            prev  <= 1'b0;
            cap   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= sync;
            cap   <= (cap & ~clr) | edge_det;
        end
    end
endmodule

module soc_system_gpio_pio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_TYPE   = 0,
    parameter int          IRQ_MODE    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);
    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_next;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign cap_clr   = (wr && address == 3'd3) ? wd : '0;
    assign out_port  = data_out;
    assign oe_port   = direction;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        soc_system_gpio_pio_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_TYPE  (EDGE_TYPE)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[i]),
            .clr    (cap_clr[i]),
            .sync   (in_sync[i]),
            .cap    (edge_capture[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= RESET_VALUE[WIDTH-1:0];
            direction <= '0;
            irq_mask  <= '0;
        end else if (wr) begin
            case (address)
                3'd0:    data_out  <= wd;
                3'd1:    direction <= wd;
                3'd2:    irq_mask  <= wd;
                3'd4:    data_out  <= data_out | wd;
                3'd5:    data_out  <= data_out & ~wd;
                default: ;
            endcase
        end
    end

    // Output bits read back the driven value, input bits the pin state.
    always_comb begin
        rd_next = '0;
        case (address)
            3'd0:    rd_next[WIDTH-1:0] = (direction & data_out) | (~direction & in_sync);
            3'd1:    rd_next[WIDTH-1:0] = direction;
            3'd2:    rd_next[WIDTH-1:0] = irq_mask;
            3'd3:    rd_next[WIDTH-1:0] = edge_capture;
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    if (IRQ_MODE == 1) begin : g_irq_edge
        assign irq = |(edge_capture & irq_mask);
    end else begin : g_irq_level
        assign irq = |(in_sync & irq_mask);
    end
endmodule

// File: doc/soc_system_gpio_pio.md
Name: soc_system_gpio_pio

Overview:
- Parametrised Avalon-MM GPIO slave, successor to the fixed 4-bit LED PIO.
- Per-bit direction control and set/clear output writes.
- Synchronised inputs with edge capture and a maskable interrupt.
- Sits on the HPS lightweight bridge and drives board LEDs, switches and keys from one block type.

Parameters:
- WIDTH, 8, number of GPIO bits (1..32).
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- IRQ_MODE, 1, interrupt source: 0 level (synchronised input), 1 edge (capture register).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above WIDTH ignored
- readdata  out  32  registered read data, zero-extended
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- oe_port  out  WIDTH  per-bit output enable (direction register)
- irq  out  1  active-high interrupt

Behaviour:
- Reset: all registers clear asynchronously when reset_n is low, including mid-transaction. Reset values:
  - data_out = RESET_VALUE; direction = 0; irq_mask = 0; edge_capture = 0.
  - Synchroniser and previous-sample registers = 0; readdata = 0.
  - Consequently irq = 0 and oe_port = 0.
- Write strobe: wr = chipselect & ~write_n. Writes take effect on the next rising clk edge.
- Register map (word address):
  - 0 DATA. Write: data_out <= writedata. Read: bit i = direction[i] ? data_out[i] : in_sync[i].
  - 1 DIRECTION. Read/write; 1 = output.
  - 2 IRQ_MASK. Read/write.
  - 3 EDGE_CAPTURE. Read returns captured bits. Write is write-1-to-clear per bit.
  - 4 OUTSET. data_out <= data_out | writedata. Reads return 0.
  - 5 OUTCLEAR. data_out <= data_out & ~writedata. Reads return 0.
  - 6, 7: reads return 0; writes ignored.
- Read: readdata is registered every cycle from the current address, regardless of chipselect. Data appears one cycle after the address is presented (fixed read latency 1).
- Input path:
  - in_port passes through a SYNC_STAGES flop chain to give in_sync.
  - in_prev holds in_sync delayed one cycle.
  - Edge detect per bit:
    - rising: in_sync & ~in_prev
    - falling: ~in_sync & in_prev
    - any: in_sync ^ in_prev
  - Latency from pin change to edge_capture set: SYNC_STAGES+1 clocks.
- Edge capture:
  - A bit sets on a detected edge and holds until cleared.
  - Simultaneous edge and write-1-to-clear on the same bit in the same cycle: set wins, so the edge is never lost.
  - Clearing bits that are 0 has no effect.
- Interrupt:
  - irq = |(edge_capture & irq_mask) when IRQ_MODE = 1.
  - irq = |(in_sync & irq_mask) when IRQ_MODE = 0.
  - irq is combinational from registers and glitch-free.
  - In IRQ_MODE 1 it deasserts the cycle after the clearing write (unless the set-wins case applies).
- Direction affects only oe_port and the DATA readback. Edge capture runs on every bit regardless of direction.
- Width rules:
  - Writes use writedata[WIDTH-1:0].
  - Reads zero-extend to 32 bits.
  - Bits [31:WIDTH] of readdata are always 0.

Test Plan:
- Reset then DATA write: WIDTH=8, RESET_VALUE=0x5A; assert reset -> out_port=0x5A, oe_port=0, irq=0, readdata=0. Write DATA 0x1234_00C3 -> out_port=0xC3 next cycle.
- Set/clear: out_port=0xC3; OUTSET 0x0C -> 0xCF; OUTCLEAR 0x81 -> 0x4E. Reads of addresses 4 and 5 return 0.
- Mixed readback: direction=0xF0, data_out=0xA0, in_port=0x05. Read DATA -> 0xA5 one cycle after address, once in_port has been stable SYNC_STAGES cycles.
- Rising edge capture, EDGE_TYPE=0, IRQ_MODE=1:
  - mask=0x01; drive in_port bit0 0->1 -> edge_capture=0x01 after 3 clocks (SYNC_STAGES=2), irq=1.
  - Write 0x01 to address 3 -> capture 0, irq=0 next cycle.
  - A 1->0 transition causes no capture.
- Set-wins collision: schedule the bit0 rising edge detection in the same cycle as a clear write of 0x01 -> edge_capture[0] stays 1 and irq stays 1.
- Level IRQ and async reset mid-operation:
  - IRQ_MODE=0, mask=0x80, in_port[7]=1 -> irq=1 after 2 clocks.
  - Pulse reset_n low between clock edges -> irq, out_port, oe_port and readdata go to reset values immediately, without waiting for a clock edge.
